// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and its issuing sequencer.
// Covers opcode constants, flag layout, dest encoding, sequencer states and opcode-class helpers.
package alu_pkg;

    localparam int OPCODE_W = 6;
    localparam int FLAGS_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP     = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_ADD     = 6'd1;
    localparam logic [OPCODE_W-1:0] OP_SUB     = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_RSVD_LO = 6'd20;
    localparam logic [OPCODE_W-1:0] OP_RSVD_HI = 6'd22;
    localparam logic [OPCODE_W-1:0] OP_LAST    = 6'd24;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam int DEST_D   = 0;
    localparam int DEST_MEM = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_t;

    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        return (op != OP_NOP) && (op <= OP_LAST) &&
               !((op >= OP_RSVD_LO) && (op <= OP_RSVD_HI));
    endfunction

    function automatic logic needs_m(input logic [OPCODE_W-1:0] op);
        logic r;
        case (op)
            6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
            6'd9, 6'd10, 6'd11,
            6'd14, 6'd15, 6'd19, 6'd24: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    // Only add/subtract produce meaningful carry and negative for the architectural flags.
    function automatic logic updates_cn(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake and data-memory bus of the ALU op sequencer.
// The master modport is the sequencer side; slave is the instruction source and memory.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [5:0]        instr_opcode;
    logic [1:0]        instr_dest;
    logic [ADDR_W-1:0] instr_addr;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  instr_valid, instr_opcode, instr_dest, instr_addr,
        output instr_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output instr_valid, instr_opcode, instr_dest, instr_addr,
        input  instr_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/alu_op_sequencer_ack_timeout_counter.sv
// Counts cycles spent waiting for a memory acknowledge and flags the abort point.
// expired is combinational so the sequencer can leave on the limit edge itself.
module ack_timeout_counter #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] timer_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (start) begin
            timer_q <= '0;
        end else if (active && !ack) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Expiry fires in the last waiting cycle, so mem_req is held for exactly ACK_TIMEOUT cycles.
    generate
        if (ACK_TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = active && !ack && (timer_q == CNT_W'(ACK_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/alu_op_sequencer.sv
// Issuing side of the 16-bit ALU: accepts an instruction, fetches M if needed,
// drives the ALU for one cycle and writes the result to D and/or memory.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.master  bus,
    output logic [5:0]          alu_opcode,
    output logic [DATA_W-1:0]   alu_d,
    output logic [DATA_W-1:0]   alu_m,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [3:0]          alu_flags,
    output logic [DATA_W-1:0]   d_reg,
    output logic [3:0]          flags_q,
    output logic                done,
    output logic                err
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [5:0]        op_q;
    logic [1:0]        dest_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] result_q;
    logic              done_d;
    logic              err_d;
    logic              in_mem_phase;
    logic              timer_start;
    logic              expired;

    assign in_mem_phase = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign timer_start  = (state_d != state_q) &&
                          ((state_d == ST_READ) || (state_d == ST_WRITE));

    ack_timeout_counter #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (timer_start),
        .active (in_mem_phase),
        .ack    (bus.mem_ack),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    if (!is_legal(bus.instr_opcode)) begin
                        err_d = 1'b1;
                    end else if (needs_m(bus.instr_opcode)) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_READ: begin
                if (bus.mem_ack) begin
                    state_d = ST_EXEC;
                end else if (expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_EXEC: begin
                if (dest_q[DEST_MEM]) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        alu_opcode      = '0;
        alu_d           = '0;
        alu_m           = '0;
        case (state_q)
            ST_IDLE: bus.instr_ready = 1'b1;
            ST_READ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_q;
            end
            ST_EXEC: begin
                alu_opcode = op_q;
                alu_d      = d_reg;
                alu_m      = m_q;
            end
            ST_WRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = result_q;
            end
            default: ;
        endcase
    end

    // Datapath latches, architectural D/flags and the registered done/err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            dest_q   <= '0;
            addr_q   <= '0;
            m_q      <= '0;
            result_q <= '0;
            d_reg    <= '0;
            flags_q  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= done_d;
            err  <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        op_q   <= bus.instr_opcode;
                        dest_q <= bus.instr_dest;
                        addr_q <= bus.instr_addr;
                        if (is_legal(bus.instr_opcode) && !needs_m(bus.instr_opcode)) begin
                            m_q <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (bus.mem_ack) begin
                        m_q <= bus.mem_rdata;
                    end
                end
                ST_EXEC: begin
                    result_q        <= alu_result;
                    flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
                    flags_q[FLAG_V] <= alu_flags[FLAG_V];
                    if (updates_cn(op_q)) begin
                        flags_q[FLAG_C] <= alu_flags[FLAG_C];
                        flags_q[FLAG_N] <= alu_flags[FLAG_N];
                    end
                    if (dest_q[DEST_D]) begin
                        d_reg <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small ALU model and a memory responder.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_d;
    logic [15:0] alu_m;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic [15:0] d_reg;
    logic [3:0]  flags_q;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic        ack_en;
    int          ack_delay;
    int          wait_cnt;
    int          req_cycles;
    int          wr_count;
    logic [7:0]  last_waddr;
    logic [15:0] last_wdata;
    logic [15:0] mem [256];
    logic [16:0] alu_wide;

    alu_op_sequencer_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    alu_op_sequencer #(
        .DATA_W     (16),
        .ADDR_W     (8),
        .ACK_TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_opcode(alu_opcode),
        .alu_d     (alu_d),
        .alu_m     (alu_m),
        .alu_result(alu_result),
        .alu_flags (alu_flags),
        .d_reg     (d_reg),
        .flags_q   (flags_q),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: 1 ADD, 2 SUB, 3 pass M, 7 D+1, 17 constant one.
    always_comb begin
        alu_wide   = '0;
        alu_result = '0;
        alu_flags  = '0;
        case (alu_opcode)
            6'd1: begin
                alu_wide     = {1'b0, alu_d} + {1'b0, alu_m};
                alu_result   = alu_wide[15:0];
                alu_flags[3] = alu_wide[16];
                alu_flags[0] = (alu_d[15] == alu_m[15]) && (alu_result[15] != alu_d[15]);
            end
            6'd2: begin
                alu_wide     = {1'b0, alu_d} - {1'b0, alu_m};
                alu_result   = alu_wide[15:0];
                alu_flags[3] = alu_wide[16];
                alu_flags[0] = (alu_d[15] != alu_m[15]) && (alu_result[15] != alu_d[15]);
            end
            6'd3: alu_result = alu_m;
            6'd7: begin
                alu_wide     = {1'b0, alu_d} + 17'd1;
                alu_result   = alu_wide[15:0];
                alu_flags[3] = alu_wide[16];
                alu_flags[0] = (alu_result == 16'h8000);
            end
            6'd17: alu_result = 16'h0001;
            default: alu_result = '0;
        endcase
        alu_flags[2] = alu_result[15];
        alu_flags[1] = (alu_result == 16'h0000);
    end

    // Memory responder: acks after ack_delay waiting cycles, decided on the falling edge.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'h0001;
        mem[8'h20] = 16'h0001;
        mem[8'h30] = 16'h7FFF;
        mem[8'h31] = 16'h0000;
        mem[8'h40] = 16'h1234;
        mem[8'h41] = 16'hBEEF;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt   = 0;
        req_cycles = 0;
        wr_count   = 0;
        last_waddr = '0;
        last_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) req_cycles++;
            if (bus.mem_req && !bus.mem_ack && ack_en) begin
                if (wait_cnt == ack_delay) begin
                    bus.mem_ack = 1'b1;
                    wait_cnt    = 0;
                    if (bus.mem_we) begin
                        mem[bus.mem_addr] = bus.mem_wdata;
                        last_waddr = bus.mem_addr;
                        last_wdata = bus.mem_wdata;
                        wr_count++;
                    end else begin
                        bus.mem_rdata = mem[bus.mem_addr];
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                if (!bus.mem_req) wait_cnt = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one instruction at +1 after an edge while the sequencer is idle; returns just after the accept edge.
    task automatic issue(input logic [5:0] op, input logic [1:0] dest, input logic [7:0] addr);
        bus.instr_valid  = 1'b1;
        bus.instr_opcode = op;
        bus.instr_dest   = dest;
        bus.instr_addr   = addr;
        @(posedge clk);
        #1;
        bus.instr_valid  = 1'b0;
    endtask

    // Edges counted after the accept edge until done or err rises, bounded.
    task automatic wait_retire(output int cyc);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done || err) break;
        end
    endtask

    initial begin
        int cyc;
        int wr0;
        int rq0;
        logic [5:0] bad_ops [5];
        bad_ops[0] = 6'd0;
        bad_ops[1] = 6'd20;
        bad_ops[2] = 6'd22;
        bad_ops[3] = 6'd25;
        bad_ops[4] = 6'd63;

        ack_en           = 1'b1;
        ack_delay        = 0;
        rst_n            = 1'b0;
        bus.instr_valid  = 1'b0;
        bus.instr_opcode = '0;
        bus.instr_dest   = '0;
        bus.instr_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check_eq("rst_ready", bus.instr_ready, 1'b1);
        check_eq("rst_d_reg", d_reg, 16'h0000);
        check_eq("rst_flags", flags_q, 4'h0);
        check_eq("rst_mem_req", bus.mem_req, 1'b0);
        check_eq("rst_done_err", {done, err}, 2'b00);
        check_eq("rst_alu_out", {alu_opcode, alu_d, alu_m}, 38'h0);

        issue(6'd17, 2'b01, 8'h00);
        check_eq("one_alu_opcode", alu_opcode, 6'd17);
        check_eq("one_ready_busy", bus.instr_ready, 1'b0);
        wait_retire(cyc);
        check_eq("one_latency", cyc + 1, 2);
        check_eq("one_done", done, 1'b1);
        check_eq("one_d_reg", d_reg, 16'h0001);
        check_eq("one_flags", flags_q, 4'b0000);

        issue(6'd3, 2'b01, 8'h30);
        wait_retire(cyc);
        check_eq("ld7fff_latency", cyc + 1, 3);
        check_eq("ld7fff_d_reg", d_reg, 16'h7FFF);

        wr0 = wr_count;
        issue(6'd1, 2'b10, 8'h10);
        wait_retire(cyc);
        check_eq("add_latency", cyc + 1, 4);
        check_eq("add_done", {done, err}, 2'b10);
        check_eq("add_writes", wr_count - wr0, 1);
        check_eq("add_waddr", last_waddr, 8'h10);
        check_eq("add_wdata", last_wdata, 16'h8000);
        check_eq("add_flags", flags_q, 4'b0101);
        check_eq("add_d_reg", d_reg, 16'h7FFF);
        @(posedge clk);
        #1;
        check_eq("add_done_pulse", done, 1'b0);

        issue(6'd3, 2'b01, 8'h31);
        wait_retire(cyc);
        check_eq("ld0_d_reg", d_reg, 16'h0000);
        check_eq("ld0_flags", flags_q, 4'b0110);
        issue(6'd2, 2'b01, 8'h20);
        wait_retire(cyc);
        check_eq("sub_d_reg", d_reg, 16'hFFFF);
        check_eq("sub_flags", flags_q, 4'b1100);
        issue(6'd7, 2'b01, 8'h00);
        wait_retire(cyc);
        check_eq("inc_d_reg", d_reg, 16'h0000);
        check_eq("inc_flags", flags_q, 4'b1110);

        issue(6'd17, 2'b00, 8'h00);
        wait_retire(cyc);
        check_eq("dest00_done", done, 1'b1);
        check_eq("dest00_d_reg", d_reg, 16'h0000);
        check_eq("dest00_flags", flags_q, 4'b1100);

        rq0 = req_cycles;
        for (int i = 0; i < 5; i++) begin
            issue(bad_ops[i], 2'b11, 8'h10);
            check_eq("illegal_err", {err, done}, 2'b10);
            check_eq("illegal_ready", bus.instr_ready, 1'b1);
            @(posedge clk);
            #1;
            check_eq("illegal_err_pulse", err, 1'b0);
        end
        check_eq("illegal_no_req", req_cycles - rq0, 0);
        check_eq("illegal_d_flags", {d_reg, flags_q}, {16'h0000, 4'b1100});

        ack_delay = 3;
        issue(6'd3, 2'b01, 8'h40);
        wait_retire(cyc);
        check_eq("ack_at_limit", {done, err}, 2'b10);
        check_eq("ack_at_limit_latency", cyc + 1, 6);
        check_eq("ack_at_limit_d", d_reg, 16'h1234);
        ack_delay = 0;

        ack_en = 1'b0;
        rq0 = req_cycles;
        issue(6'd3, 2'b01, 8'h41);
        wait_retire(cyc);
        check_eq("tmo_err", {err, done}, 2'b10);
        check_eq("tmo_cycles", cyc, 4);
        check_eq("tmo_req_cycles", req_cycles - rq0, 4);
        check_eq("tmo_ready", bus.instr_ready, 1'b1);
        check_eq("tmo_d_reg", d_reg, 16'h1234);

        issue(6'd3, 2'b01, 8'h41);
        @(posedge clk);
        #1;
        check_eq("midread_req", bus.mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_mem_req", bus.mem_req, 1'b0);
        check_eq("arst_d_reg", d_reg, 16'h0000);
        check_eq("arst_flags", flags_q, 4'h0);
        #3;
        rst_n  = 1'b1;
        ack_en = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_ready", bus.instr_ready, 1'b1);
        check_eq("arst_idle_outs", {bus.mem_req, done, err}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issuing end of the 16-bit ALU interface; the ALU is instantiated beside this block, not inside it.
- Accepts one instruction per valid/ready handshake and fetches the M operand from data memory when the opcode needs it.
- Drives the ALU opcode and D/M inputs for one cycle, then writes the result back to the D register and/or memory and holds the architectural flags.

Parameters:
- DATA_W, 16, operand/result width; must equal the ALU width; only 16 is supported.
- ADDR_W, 8, data-memory address width.
- ACK_TIMEOUT, 15, maximum cycles waiting for mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept; high iff state IDLE.
- instr_opcode  in  6  ALU opcode.
- instr_dest  in  2  bit0 = write D, bit1 = write memory.
- instr_addr  in  ADDR_W  memory address for M read and/or write.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- alu_opcode  out  6  to ALU.
- alu_d  out  DATA_W  to ALU D.
- alu_m  out  DATA_W  to ALU M.
- alu_result  in  DATA_W  from ALU.
- alu_flags  in  4  from ALU: [3] carry, [2] negative, [1] zero, [0] overflow.
- d_reg  out  DATA_W  architectural D register.
- flags_q  out  4  architectural flags, same layout as alu_flags.
- done  out  1  one-cycle pulse: instruction retired.
- err  out  1  one-cycle pulse: illegal opcode or memory timeout.

Behaviour:
- Reset (async, rst_n low): state IDLE; d_reg=0, flags_q=0, op/addr/m/result latches=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, alu_opcode=0, alu_d=0, alu_m=0, done=0, err=0, timer=0. Reset mid-transaction abandons it with no write-back.
- States: IDLE, READ, EXEC, WRITE.
- IDLE:
  - instr_ready=1.
  - On instr_valid: latch opcode, dest, addr.
  - Illegal opcode (000000, 010100–010110, >011000): next state IDLE, err pulse next cycle, nothing else changes.
  - Legal and needs_m: go to READ.
  - Otherwise: go to EXEC with m latch=0.
- needs_m opcodes: 000001–000101, 001001–001011, 001110, 001111, 010011, 011000.
- READ:
  - mem_req=1, mem_we=0, mem_addr=addr.
  - On mem_ack: m latch<=mem_rdata, go to EXEC.
- EXEC (exactly one cycle):
  - alu_opcode=op, alu_d=d_reg, alu_m=m latch.
  - At the closing edge: result latch<=alu_result; flags_q[1:0]<=alu_flags[1:0].
  - flags_q[3:2]<=alu_flags[3:2] only for opcodes 000001/000010; otherwise they are retained.
  - If dest[0]: d_reg<=alu_result.
  - If dest[1]: go to WRITE; else go to IDLE with done pulse.
  - dest=00 is legal: flags are updated only.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=result latch.
  - On mem_ack: go to IDLE with done pulse.
- Outside EXEC: alu_opcode=0, alu_d=0, alu_m=0.
- Timeout: timer clears on entry to READ/WRITE and increments each cycle without mem_ack. When it reaches ACK_TIMEOUT: drop mem_req, go to IDLE, err pulse. Latches and d_reg are unchanged, except that dest[0] D updates made in EXEC persist.
- mem_ack on the same cycle the timer hits the limit counts as success.
- mem_ack outside READ/WRITE is ignored.
- done/err are registered and coincide with the IDLE cycle, so a new instruction may be accepted in that cycle.
- Latency from accept edge to done-high:
  - Non-memory instruction: 2 cycles (throughput 1 instruction per 2 cycles).
  - Each memory phase adds 1 + ack-wait cycles.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams.
  - Flag bit indices.
  - dest encoding.
  - State enum.
  - Functions is_legal(op), needs_m(op), updates_cn(op).
  - The ALU should import the same opcode constants.
- One natural sub-module: ack_timeout_counter (start, ack, expired; parameter ACK_TIMEOUT).

Test Plan:
- Reset asserted mid-READ -> mem_req falls in the same cycle without a clock edge; d_reg=0x0000, flags_q=0, instr_ready=1 after release.
- Accept 010001 dest=01 at edge N -> alu_opcode=010001 during cycle N+1; d_reg=0x0001, done=1 during cycle N+2; flags_q=0000.
- d_reg=0x7FFF, mem[0x10]=0x0001, 000001 dest=10 addr=0x10 -> read 0x10, then write 0x10 data 0x8000; flags_q=0101; d_reg stays 0x7FFF; one done.
- d_reg=0x0000, mem[0x20]=0x0001, 000010 dest=01 -> d_reg=0xFFFF, flags_q=1100; then 000111 dest=01 -> d_reg=0x0000, flags_q=1110 (carry/negative retained).
- Opcode 010100 offered -> err one cycle, no mem_req, d_reg/flags unchanged, instr_ready high the next cycle.
- ACK_TIMEOUT=4, mem_ack tied low, READ instruction -> mem_req high exactly 4 cycles, then err pulse, IDLE, d_reg unchanged.
